fetch_ctrl: RTL
===============

# fetch_ctrl

Sequencing controller for the 32-bit program counter and the instruction-memory fetch port. Each cycle it selects the next-PC source and generates the PC load enable. It runs the request/ready handshake with instruction memory and holds fetch on decode stalls. It records jump/branch/jr redirects that arrive while a fetch is outstanding, and flushes wrong-path instructions. It sits between the PC register (driving its select and enable) and the decode stage.

## Interface
Parameters:
- CNT_W, 32, width of the fetched-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request to instruction memory (address = current PC)
- imem_ready  in  1  memory returns instruction this cycle; completes request
- stall  in  1  decode cannot accept an instruction this cycle
- br_taken  in  1  execute: taken conditional branch, target on jal_br_target path
- jal  in  1  execute: jal, target on jal_br_target path
- jr  in  1  execute: jr, target on jr_target path
- halt  in  1  stop fetching after current request completes
- pc_sel  out  2  next-PC source: 2'b00 pc+4, 2'b01 jal/branch target, 2'b10 jr target; 2'b11 never driven
- pc_en  out  1  PC register loads the selected value at this edge
- inst_valid  out  1  instruction on memory bus is valid for decode this cycle
- flush  out  1  kill instruction currently in decode
- halted  out  1  controller in HALT
- fetch_count  out  CNT_W  number of cycles with inst_valid=1, wraps modulo 2^CNT_W

## Operation
- States: BOOT, FETCH, REDIR, HALT. Registered: state, pend_sel[1:0], fetch_count.
- redirect = jr | jal | br_taken. Code: jr → 2'b10 (highest priority), else jal|br_taken → 2'b01.
- BOOT: imem_req=0, pc_en=0. Next state is FETCH unconditionally. The first request issues one cycle after reset release, from PC=0.
- FETCH: imem_req=1. Once asserted, imem_req stays high until imem_ready, with no withdrawal.
  - ready & redirect: pc_en=1, pc_sel=code, flush=1, inst_valid=0; stay FETCH.
  - ready & !redirect & halt: pc_en=0, inst_valid=0; go to HALT.
  - ready & !redirect & stall: pc_en=0, inst_valid=0; stay FETCH and refetch the same PC.
  - ready & none of the above: pc_en=1, pc_sel=00, inst_valid=1.
  - !ready & redirect: pc_en=0, flush=1, pend_sel<=code; go to REDIR.
  - !ready & !redirect: pc_en=0.
- REDIR: imem_req=1, because the wrong-path request is still outstanding.
  - ready: pc_en=1, pc_sel=pend_sel, inst_valid=0; go to FETCH.
  - A newer redirect arriving in REDIR overwrites pend_sel and asserts flush. On the ready cycle, a same-cycle redirect wins over pend_sel.
  - halt is ignored in REDIR.
- HALT: all outputs 0 except halted=1. Left only via rst.
- Redirect outranks halt and stall. halt outranks stall.
- fetch_count increments on every cycle with inst_valid=1.

## Timing
- pc_sel, pc_en, inst_valid and flush are combinational (Mealy) from state and inputs. The PC register samples them at the same edge.
- imem_req is a function of state only.
- Best-case throughput: with imem_ready tied high, one instruction per cycle.
- Redirect penalty: with ready, the target PC is loaded at the redirect edge, and the target instruction is fetched on the next cycle.
- Reset (asynchronous, any cycle, including mid-request): state=BOOT, pend_sel=00, fetch_count=0. All outputs immediately read 0 and pc_sel=00. An outstanding memory request is abandoned.

## Test plan
- Reset, then imem_ready=1 constant → BOOT for 1 cycle, then pc_en=1/pc_sel=00/inst_valid=1 every cycle; fetch_count=10 after 10 fetch cycles.
- imem_ready high only every 3rd cycle → imem_req stays high continuously; pc_en and inst_valid pulse only on ready cycles.
- jr and br_taken pulsed together on a ready cycle → pc_sel=10, pc_en=1, flush=1, inst_valid=0.
- jal pulsed while !ready, ready 2 cycles later → flush on jal cycle; REDIR held; on ready pc_sel=01, pc_en=1, inst_valid=0; FETCH next.
- stall=1 for 4 ready cycles then 0 → pc_en=0, inst_valid=0 during stall; same PC refetched; fetch_count unchanged until release.
- halt on ready cycle, then rst pulsed mid-HALT → halted=1 and outputs 0 one cycle later; rst immediately clears halted; BOOT then FETCH resume.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: picks the next-PC source, gates PC loads, runs the imem req/ready
// handshake, parks redirects that land while a fetch is outstanding, and flushes wrong-path work.
module fetch_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   input  logic             imem_ready,
   input  logic             stall,
   input  logic             br_taken,
   input  logic             jal,
   input  logic             jr,
   input  logic             halt,
   output logic [1:0]       pc_sel,
   output logic             pc_en,
   output logic             inst_valid,
   output logic             flush,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_count
);

   localparam logic [1:0] S_BOOT  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_REDIR = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   localparam logic [1:0] SEL_PC4 = 2'b00;
   localparam logic [1:0] SEL_JBR = 2'b01;
   localparam logic [1:0] SEL_JR  = 2'b10;

   logic [1:0]       r_state;
   logic [1:0]       r_pend_sel;
   logic [CNT_W-1:0] r_fetch_count;

   logic [1:0]       w_state_nxt;
   logic [1:0]       w_pend_nxt;
   logic             w_redirect;
   logic [1:0]       w_code;

   assign w_redirect = jr | jal | br_taken;
   assign w_code     = jr ? SEL_JR : (w_redirect ? SEL_JBR : SEL_PC4);

   // imem_req depends on state only, so a request never drops before its ready
   assign imem_req    = (r_state == S_FETCH) || (r_state == S_REDIR);
   assign halted      = (r_state == S_HALT);
   assign fetch_count = r_fetch_count;

   always_comb begin
      w_state_nxt = r_state;
      w_pend_nxt  = r_pend_sel;
      pc_sel      = SEL_PC4;
      pc_en       = 1'b0;
      inst_valid  = 1'b0;
      flush       = 1'b0;
      case (r_state)
         S_BOOT: begin
            w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ready) begin
               if (w_redirect) begin
                  pc_en  = 1'b1;
                  pc_sel = w_code;
                  flush  = 1'b1;
               end else if (halt) begin
                  w_state_nxt = S_HALT;
               end else if (!stall) begin
                  pc_en      = 1'b1;
                  inst_valid = 1'b1;
               end
            end else if (w_redirect) begin
               // wrong-path fetch still in flight; remember where to go once it returns
               flush       = 1'b1;
               w_pend_nxt  = w_code;
               w_state_nxt = S_REDIR;
            end
         end
         S_REDIR: begin
            if (w_redirect) begin
               flush      = 1'b1;
               w_pend_nxt = w_code;
            end
            if (imem_ready) begin
               pc_en       = 1'b1;
               pc_sel      = w_redirect ? w_code : r_pend_sel;
               w_state_nxt = S_FETCH;
            end
         end
         default: begin
            w_state_nxt = S_HALT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_BOOT;
         r_pend_sel    <= SEL_PC4;
         r_fetch_count <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pend_sel <= w_pend_nxt;
         if (inst_valid) begin
            r_fetch_count <= r_fetch_count + CNT_W'(1);
         end
      end
   end

endmodule
